pixel_filter_ctrl: RTL and testbench

- Parametrised successor of the fixed 12-bit key/filter/display top.
- Debounces five user keys on an internal 1 kHz tick and keeps a filter mode and a level value under key control.
- Applies the selected per-pixel filter to an NUM_CH x CH_BITS pixel stream through a 2-stage valid-qualified pipeline.
- Scans mode and level onto an 8-digit seven-segment display. Sits between the camera capture path and the VGA/display path.

---
 rtl/pixel_filter_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_pixel_filter_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_filter_ctrl.sv
// Key-controlled pixel filter: debounced keys set mode/level, a 2-stage pipeline
// filters the pixel stream, and a scanned seven-segment display shows the settings.
module pixel_filter_ctrl #(
    parameter int CH_BITS   = 4,
    parameter int NUM_CH    = 3,
    parameter int PLS_DIV   = 50000,
    parameter int DEB_TICKS = 20,
    parameter int LEVEL_RST = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4:0]                key_in,
    input  logic [NUM_CH*CH_BITS-1:0] pixel_in,
    input  logic                      pixel_in_valid,
    input  logic                      frame_start,
    output logic [NUM_CH*CH_BITS-1:0] pixel_out,
    output logic                      pixel_out_valid,
    output logic [4:0]                key_out,
    output logic [2:0]                mode,
    output logic [CH_BITS-1:0]        level,
    output logic [7:0]                o_seg_d,
    output logic [7:0]                o_seg_com,
    output logic                      edgeon
);
    localparam int PW = NUM_CH * CH_BITS;
    localparam int CW = (PLS_DIV > 1) ? $clog2(PLS_DIV) : 1;
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int SW = CH_BITS + $clog2(NUM_CH) + 2;
    localparam logic [CH_BITS-1:0] CMAX    = {CH_BITS{1'b1}};
    localparam logic [CH_BITS-1:0] LVL_RST = CH_BITS'(LEVEL_RST);
    localparam logic [2:0] M_INVERT = 3'd1;
    localparam logic [2:0] M_GRAY   = 3'd2;
    localparam logic [2:0] M_THRESH = 3'd3;
    localparam logic [2:0] M_BRIGHT = 3'd4;
    localparam logic [2:0] M_EDGE   = 3'd5;
    localparam logic [2:0] M_LAST   = 3'd5;

    function automatic logic [CH_BITS-1:0] chan(input logic [PW-1:0] p, input int i);
        return p[(NUM_CH-1-i)*CH_BITS +: CH_BITS];
    endfunction

    function automatic logic [CH_BITS-1:0] gray_of(input logic [PW-1:0] p);
        logic [SW-1:0] sum;
        sum = '0;
        if (NUM_CH == 3) begin
            sum = SW'(chan(p, 0)) + (SW'(chan(p, 1)) << 1) + SW'(chan(p, 2));
            return CH_BITS'(sum >> 2);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                sum = sum + SW'(chan(p, i));
            end
            return CH_BITS'(sum / SW'(NUM_CH));
        end
    endfunction

    // Active-low gfedcba pattern with the decimal point held off.
    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    logic [4:0]          key_meta_q, key_meta_d, key_sync_q, key_sync_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tick_s;
    logic [4:0]          deb_q, deb_d, press_q, press_d;
    logic [4:0][DW-1:0]  dcnt_q, dcnt_d;
    logic [2:0]          pending_q, pending_d, mode_q, mode_d;
    logic [CH_BITS-1:0]  level_q, level_d;
    logic                edgeon_q, edgeon_d, commit_s;
    logic                s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
    logic [PW-1:0]       s1_pix_q, s1_pix_d, pixel_out_q, pixel_out_d, res_s;
    logic [2:0]          s1_mode_q, s1_mode_d;
    logic [CH_BITS-1:0]  s1_gray_q, s1_gray_d, s1_prev_q, s1_prev_d;
    logic [CH_BITS-1:0]  prev_gray_q, prev_gray_d, gray_in_s, diff_s;
    logic [CH_BITS:0]    bsum_s;
    logic [2:0]          digit_q, digit_d;
    logic [7:0]          seg_q, seg_d, com_q, com_d;
    logic [CH_BITS+7:0]  lvl_ext_s;

    // Key synchroniser, tick divider and per-key debounce.
    always_comb begin
        key_meta_d = key_in;
        key_sync_d = key_meta_q;
        tick_s     = (cnt_q == CW'(PLS_DIV - 1));
        cnt_d      = tick_s ? '0 : cnt_q + CW'(1);
        deb_d      = deb_q;
        dcnt_d     = dcnt_q;
        for (int i = 0; i < 5; i++) begin
            if (tick_s) begin
                if (key_sync_q[i] != deb_q[i]) begin
                    if (dcnt_q[i] == DW'(DEB_TICKS - 1)) begin
                        deb_d[i]  = key_sync_q[i];
                        dcnt_d[i] = '0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DW'(1);
                    end
                end else begin
                    dcnt_d[i] = '0;
                end
            end else begin
                dcnt_d[i] = dcnt_q[i];
            end
        end
        press_d = deb_d & ~deb_q;
    end

    // Settings update and frame-aligned mode commit; commit reads the old pending.
    always_comb begin
        pending_d = pending_q;
        level_d   = level_q;
        if (press_q[4]) begin
            pending_d = 3'd0;
            level_d   = LVL_RST;
        end else begin
            if (press_q[0]) begin
                pending_d = (pending_q == M_LAST) ? 3'd0 : pending_q + 3'd1;
            end else if (press_q[1]) begin
                pending_d = (pending_q == 3'd0) ? M_LAST : pending_q - 3'd1;
            end else begin
                pending_d = pending_q;
            end
            if (press_q[2] && !press_q[3]) begin
                level_d = (level_q == CMAX) ? CMAX : level_q + CH_BITS'(1);
            end else if (press_q[3] && !press_q[2]) begin
                level_d = (level_q == '0) ? '0 : level_q - CH_BITS'(1);
            end else begin
                level_d = level_q;
            end
        end
        commit_s = pixel_in_valid & frame_start;
        mode_d   = commit_s ? pending_q : mode_q;
        edgeon_d = (mode_d == M_EDGE);
    end

    // Stage 1 captures pixel, gray and the mode this pixel's frame runs in.
    always_comb begin
        gray_in_s   = gray_of(pixel_in);
        s1_valid_d  = pixel_in_valid;
        s1_pix_d    = s1_pix_q;
        s1_mode_d   = s1_mode_q;
        s1_gray_d   = s1_gray_q;
        s1_prev_d   = s1_prev_q;
        prev_gray_d = prev_gray_q;
        if (pixel_in_valid) begin
            s1_pix_d    = pixel_in;
            s1_mode_d   = mode_d;
            s1_gray_d   = gray_in_s;
            s1_prev_d   = frame_start ? gray_in_s : prev_gray_q;
            prev_gray_d = gray_in_s;
        end else begin
            prev_gray_d = prev_gray_q;
        end
    end

    // Stage 2 applies the filter operation.
    always_comb begin
        diff_s = (s1_gray_q >= s1_prev_q) ? s1_gray_q - s1_prev_q : s1_prev_q - s1_gray_q;
        bsum_s = '0;
        res_s  = s1_pix_q;
        case (s1_mode_q)
            M_INVERT: res_s = ~s1_pix_q;
            M_GRAY:   res_s = {NUM_CH{s1_gray_q}};
            M_THRESH: res_s = (s1_gray_q >= level_q) ? {PW{1'b1}} : {PW{1'b0}};
            M_BRIGHT: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    bsum_s = {1'b0, chan(s1_pix_q, i)} + {1'b0, level_q};
                    res_s[(NUM_CH-1-i)*CH_BITS +: CH_BITS] = bsum_s[CH_BITS] ? CMAX : bsum_s[CH_BITS-1:0];
                end
            end
            M_EDGE:   res_s = (diff_s > level_q) ? {PW{1'b1}} : {PW{1'b0}};
            default:  res_s = s1_pix_q;
        endcase
        out_valid_d = s1_valid_q;
        pixel_out_d = s1_valid_q ? res_s : pixel_out_q;
    end

    // Display scan: common and segment registers move together.
    always_comb begin
        digit_d   = tick_s ? digit_q + 3'd1 : digit_q;
        com_d     = ~(8'd1 << digit_d);
        lvl_ext_s = {8'd0, level_q};
        case (digit_d)
            3'd0:    seg_d = hex7({1'b0, mode_q});
            3'd1:    seg_d = hex7({1'b0, pending_q});
            3'd2:    seg_d = hex7(lvl_ext_s[3:0]);
            3'd3:    seg_d = hex7(lvl_ext_s[7:4]);
            default: seg_d = 8'hFF;
        endcase
    end

    // Key path and settings registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= 5'd0;
            key_sync_q <= 5'd0;
            cnt_q      <= '0;
            deb_q      <= 5'd0;
            dcnt_q     <= '0;
            press_q    <= 5'd0;
            pending_q  <= 3'd0;
            level_q    <= LVL_RST;
            mode_q     <= 3'd0;
            edgeon_q   <= 1'b0;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            dcnt_q     <= dcnt_d;
            press_q    <= press_d;
            pending_q  <= pending_d;
            level_q    <= level_d;
            mode_q     <= mode_d;
            edgeon_q   <= edgeon_d;
        end
    end

    // Pixel pipeline and display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_pix_q    <= '0;
            s1_mode_q   <= 3'd0;
            s1_gray_q   <= '0;
            s1_prev_q   <= '0;
            prev_gray_q <= '0;
            out_valid_q <= 1'b0;
            pixel_out_q <= '0;
            digit_q     <= 3'd0;
            seg_q       <= 8'hFF;
            com_q       <= 8'hFE;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_pix_q    <= s1_pix_d;
            s1_mode_q   <= s1_mode_d;
            s1_gray_q   <= s1_gray_d;
            s1_prev_q   <= s1_prev_d;
            prev_gray_q <= prev_gray_d;
            out_valid_q <= out_valid_d;
            pixel_out_q <= pixel_out_d;
            digit_q     <= digit_d;
            seg_q       <= seg_d;
            com_q       <= com_d;
        end
    end

    assign pixel_out       = pixel_out_q;
    assign pixel_out_valid = out_valid_q;
    assign key_out         = deb_q;
    assign mode            = mode_q;
    assign level           = level_q;
    assign o_seg_d         = seg_q;
    assign o_seg_com       = com_q;
    assign edgeon          = edgeon_q;
endmodule

// File: tb/tb_pixel_filter_ctrl.sv
// Bench for pixel_filter_ctrl: table-driven mode vectors, key/settings sequences,
// and randomized pixel streams scored against a behavioural model.
module tb_pixel_filter_ctrl;
    localparam int HOLD = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  key_in;
    logic [11:0] pixel_in;
    logic        pixel_in_valid;
    logic        frame_start;
    logic [11:0] pixel_out;
    logic        pixel_out_valid;
    logic [4:0]  key_out;
    logic [2:0]  mode;
    logic [3:0]  level;
    logic [7:0]  o_seg_d;
    logic [7:0]  o_seg_com;
    logic        edgeon;

    always #5 clk = ~clk;

    pixel_filter_ctrl #(.CH_BITS(4), .NUM_CH(3), .PLS_DIV(4), .DEB_TICKS(3), .LEVEL_RST(8)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .pixel_in(pixel_in),
        .pixel_in_valid(pixel_in_valid), .frame_start(frame_start),
        .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid), .key_out(key_out),
        .mode(mode), .level(level), .o_seg_d(o_seg_d), .o_seg_com(o_seg_com), .edgeon(edgeon)
    );

    typedef struct {
        int          vmode;
        logic [11:0] pix;
        logic [11:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int m_mode, m_pend, m_level, m_prev;
    logic [11:0] expq[$];
    logic [11:0] obs[$];
    logic [11:0] last_out;
    bit d0, d1, d2;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_ref(input logic [11:0] p);
        return (int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0])) / 4;
    endfunction

    function automatic logic [11:0] ref_op(input int m, input logic [11:0] p, input int lvl, input int pg);
        int g, c[3], r[3];
        g = gray_ref(p);
        c[0] = int'(p[11:8]); c[1] = int'(p[7:4]); c[2] = int'(p[3:0]);
        for (int i = 0; i < 3; i++) begin
            case (m)
                1: r[i] = 15 - c[i];
                2: r[i] = g;
                3: r[i] = (g >= lvl) ? 15 : 0;
                4: r[i] = (c[i] + lvl > 15) ? 15 : c[i] + lvl;
                5: r[i] = (((g > pg) ? g - pg : pg - g) > lvl) ? 15 : 0;
                default: r[i] = c[i];
            endcase
        end
        return {4'(r[0]), 4'(r[1]), 4'(r[2])};
    endfunction

    function automatic logic [7:0] seg_ref(input int v);
        logic [7:0] t[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[v];
    endfunction

    task automatic model_press(input logic [4:0] m);
        if (m[4]) begin
            m_pend = 0; m_level = 8;
        end else begin
            if (m[0]) m_pend = (m_pend == 5) ? 0 : m_pend + 1;
            else if (m[1]) m_pend = (m_pend == 0) ? 5 : m_pend - 1;
            if (m[2] && !m[3]) m_level = (m_level == 15) ? 15 : m_level + 1;
            if (m[3] && !m[2]) m_level = (m_level == 0) ? 0 : m_level - 1;
        end
    endtask

    task automatic press(input logic [4:0] m);
        @(posedge clk); #1 key_in = m;
        repeat (HOLD) @(posedge clk);
        #1 key_in = 5'd0;
        repeat (HOLD + 4) @(posedge clk);
        #1;
        model_press(m);
    endtask

    task automatic run_cycle(input bit v, input bit fs, input logic [11:0] p);
        logic [11:0] e;
        int g;
        @(posedge clk); #1;
        pixel_in_valid = v; frame_start = fs; pixel_in = p;
        if (v) begin
            g = gray_ref(p);
            if (fs) m_mode = m_pend;
            expq.push_back(ref_op(m_mode, p, m_level, fs ? g : m_prev));
            m_prev = g;
        end
        d2 = d1; d1 = d0; d0 = v;
        @(negedge clk);
        chk("out_valid", 32'(pixel_out_valid), 32'(d2));
        if (d2) begin
            e = (expq.size() > 0) ? expq.pop_front() : 12'hXXX;
            chk("pixel_out", 32'(pixel_out), 32'(e));
            obs.push_back(pixel_out);
            last_out = e;
        end else begin
            chk("pixel_hold", 32'(pixel_out), 32'(last_out));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 12'h000);
    endtask

    task automatic check_digit(input string name, input logic [7:0] com, input logic [7:0] seg);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (o_seg_com == com) seen = 1'b1;
        end
        chk({name, "_com"}, 32'(o_seg_com), 32'(com));
        chk({name, "_seg"}, 32'(o_seg_d), 32'(seg));
    endtask

    task automatic last_obs(input string name, input logic [11:0] exp);
        chk(name, 32'(obs.size() > 0 ? obs[$] : 12'hXXX), 32'(exp));
    endtask

    initial begin
        vecs[0] = '{0, 12'hA53, 12'hA53};
        vecs[1] = '{1, 12'h0F0, 12'hF0F};
        vecs[2] = '{2, 12'h9F2, 12'hAAA};
        vecs[3] = '{3, 12'h888, 12'hFFF};
        vecs[4] = '{3, 12'h777, 12'h000};
        vecs[5] = '{4, 12'h9F2, 12'hFFA};
        vecs[6] = '{5, 12'h123, 12'h000};
        vecs[7] = '{0, 12'hFFF, 12'hFFF};
        vecs[8] = '{1, 12'hFFF, 12'h000};

        rst_n = 1'b0; key_in = 5'd0; pixel_in = 12'h000; pixel_in_valid = 1'b0; frame_start = 1'b0;
        m_mode = 0; m_pend = 0; m_level = 8; m_prev = 0; last_out = 12'h000;
        d0 = 1'b0; d1 = 1'b0; d2 = 1'b0;
        #23;
        chk("rst_pixel_out", 32'(pixel_out), 32'h0);
        chk("rst_valid", 32'(pixel_out_valid), 32'h0);
        chk("rst_key_out", 32'(key_out), 32'h0);
        chk("rst_mode", 32'(mode), 32'h0);
        chk("rst_level", 32'(level), 32'h8);
        chk("rst_seg_d", 32'(o_seg_d), 32'hFF);
        chk("rst_seg_com", 32'(o_seg_com), 32'hFE);
        chk("rst_edgeon", 32'(edgeon), 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Bypass single pixel, two-cycle latency checked per cycle.
        run_cycle(1'b1, 1'b0, 12'hA53);
        idle(3);
        last_obs("bypass_a53", 12'hA53);
        check_digit("disp_mode0", 8'hFE, 8'hC0);
        check_digit("disp_level8", 8'hFB, 8'h80);

        // Bounce on key 0 then a clean hold: exactly one next event.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 key_in = (i % 2 == 0) ? 5'b00001 : 5'b00000;
            repeat (3) @(posedge clk);
        end
        #1 key_in = 5'b00001;
        repeat (HOLD) @(posedge clk);
        #1 key_in = 5'd0;
        repeat (HOLD + 4) @(posedge clk);
        model_press(5'b00001);
        check_digit("bounce_pending", 8'hFD, seg_ref(1));
        chk("bounce_mode", 32'(mode), 32'h0);

        // Commit at frame_start; a press within the frame waits for the next frame.
        run_cycle(1'b1, 1'b1, 12'h0F0);
        idle(3);
        last_obs("commit_invert", 12'hF0F);
        chk("commit_mode", 32'(mode), 32'h1);
        press(5'b00001);
        run_cycle(1'b1, 1'b0, 12'h0F0);
        idle(3);
        last_obs("same_frame", 12'hF0F);
        chk("same_frame_mode", 32'(mode), 32'h1);
        run_cycle(1'b1, 1'b1, 12'h0F0);
        idle(3);
        last_obs("next_frame_gray", 12'h777);

        // Table of mode vectors at level 8.
        foreach (vecs[k]) begin
            while (m_pend != vecs[k].vmode) press(5'b00001);
            run_cycle(1'b1, 1'b1, vecs[k].pix);
            idle(3);
            last_obs($sformatf("vec%0d", k), vecs[k].exp);
            chk($sformatf("vec%0d_mode", k), 32'(mode), 32'(vecs[k].vmode));
        end

        // Settings corners: wrap, saturation, up+down, clear.
        press(5'b10000);
        check_digit("clear1_pending", 8'hFD, seg_ref(0));
        press(5'b00010);
        check_digit("prev_wrap", 8'hFD, seg_ref(5));
        run_cycle(1'b1, 1'b1, 12'h000);
        idle(3);
        chk("edgeon_set", 32'(edgeon), 32'h1);
        chk("mode_edge", 32'(mode), 32'h5);
        repeat (9) press(5'b00100);
        chk("level_sat", 32'(level), 32'hF);
        press(5'b01100);
        chk("level_updown", 32'(level), 32'hF);
        press(5'b10000);
        chk("clear_level", 32'(level), 32'h8);
        check_digit("clear_pending", 8'hFD, seg_ref(0));

        // EDGE with level 2: gray 4, 7, 6.
        press(5'b00010);
        repeat (6) press(5'b01000);
        chk("level_two", 32'(level), 32'h2);
        obs.delete();
        run_cycle(1'b1, 1'b1, 12'h444);
        run_cycle(1'b1, 1'b0, 12'h777);
        run_cycle(1'b1, 1'b0, 12'h666);
        idle(3);
        chk("edge_count", 32'(obs.size()), 32'd3);
        if (obs.size() == 3) begin
            chk("edge0", 32'(obs[0]), 32'h000);
            chk("edge1", 32'(obs[1]), 32'hFFF);
            chk("edge2", 32'(obs[2]), 32'h000);
        end

        // Asynchronous reset with pixels in flight.
        run_cycle(1'b1, 1'b1, 12'hABC);
        run_cycle(1'b1, 1'b0, 12'hDEF);
        #2 rst_n = 1'b0; pixel_in_valid = 1'b0; frame_start = 1'b0;
        #1;
        chk("arst_valid", 32'(pixel_out_valid), 32'h0);
        chk("arst_pixel", 32'(pixel_out), 32'h0);
        chk("arst_mode", 32'(mode), 32'h0);
        chk("arst_level", 32'(level), 32'h8);
        chk("arst_com", 32'(o_seg_com), 32'hFE);
        @(negedge clk); rst_n = 1'b1;
        m_mode = 0; m_pend = 0; m_level = 8; m_prev = 0; last_out = 12'h000;
        expq.delete(); d0 = 1'b0; d1 = 1'b0; d2 = 1'b0;
        idle(4);

        // Randomized streams against the model.
        for (int r = 0; r < 6; r++) begin
            int tmode, tlvl;
            bit v, fs;
            tmode = $urandom_range(0, 5);
            tlvl  = $urandom_range(0, 15);
            while (m_level < tlvl) press(5'b00100);
            while (m_level > tlvl) press(5'b01000);
            while (m_pend != tmode) press(5'b00001);
            for (int c = 0; c < 80; c++) begin
                v  = (c == 0) || ($urandom_range(0, 3) != 0);
                fs = v && ((c == 0) || ($urandom_range(0, 7) == 0));
                run_cycle(v, fs, 12'($urandom));
            end
            idle(3);
            chk("rand_mode", 32'(mode), 32'(tmode));
            chk("rand_level", 32'(level), 32'(tlvl));
            chk("rand_edgeon", 32'(edgeon), 32'(tmode == 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
